// File: rtl/pistorm_pkg.sv
// Shared definitions for the PiStorm CPLD: Pi register map, status/command
// bit positions and small helpers used by the Pi-side front end.
package pistorm_pkg;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_ADDR_LO = 2'd1,
    REG_ADDR_HI = 2'd2,
    REG_STATUS  = 2'd3
  } reg_sel_e;

  localparam int STATUS_RESET_BIT = 1;
  localparam int STAT_IPL_MSB     = 15;
  localparam int STAT_OVERRUN     = 12;

  localparam int CMD_BYTE = 8;
  localparam int CMD_RW   = 9;

  // Word the Pi reads back from the STATUS register address.
  function automatic logic [15:0] status_word(input logic [2:0] ipl,
                                              input logic       overrun);
    logic [15:0] w;
    w                           = '0;
    w[STAT_IPL_MSB -: 3]        = ipl;
    w[STAT_OVERRUN]             = overrun;
    return w;
  endfunction

  // Returns {UDS_N, LDS_N}. Byte accesses pick the lane from A0 (68K is
  // big-endian: even address -> upper byte), word accesses assert both.
  function automatic logic [1:0] lane_strobes(input logic byte_acc,
                                              input logic a0);
    logic [1:0] s;
    s = 2'b00;
    if (byte_acc) s = {a0, ~a0};
    return s;
  endfunction

endpackage

// File: rtl/pi_edge_sync.sv
// N-flop synchroniser for an asynchronous level, with rise/fall/change
// pulses derived from the two oldest stages.
module pi_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall,
  output logic change
);

  // sync[0] is the newest sample, sync[STAGES-1] the oldest.
  logic [STAGES-1:0] sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync <= '0;
    else     sync <= {sync[STAGES-2:0], d};
  end

  always_comb begin
    rise   = sync[STAGES-2] & ~sync[STAGES-1];
    fall   = ~sync[STAGES-2] & sync[STAGES-1];
    change = sync[STAGES-2] ^ sync[STAGES-1];
  end

endmodule

// File: rtl/pi_host_if.sv
// Pi-side front end: decodes Pi register strobes, builds 68K bus requests
// for the bus FSM via toggle handshakes, and tracks status / IPL state.
module pi_host_if
  import pistorm_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int IPL_FILTER  = 2
) (
  input  logic        PI_CLK,
  input  logic        PI_RST,
  input  logic [1:0]  PI_A,
  input  logic        PI_RD,
  input  logic        PI_WR,
  input  logic [15:0] PI_D_IN,
  output logic [15:0] PI_D_OUT,
  output logic        PI_D_OE,
  output logic        PI_TXN_IN_PROGRESS,
  output logic        PI_IPL_ZERO,
  input  logic        M68K_CLK,
  input  logic [2:0]  M68K_IPL_n,
  output logic        OP_REQ,
  output logic        OP_RW,
  output logic        OP_UDS_N,
  output logic        OP_LDS_N,
  input  logic        OP_ACK_TGL,
  input  logic        OP_DONE_TGL,
  output logic [15:0] STATUS
);

  localparam logic [2:0] FILTER_N = 3'(IPL_FILTER);

  logic rd_rise, rd_fall, rd_chg;
  logic wr_rise, wr_fall, wr_chg;
  logic m68k_rise, m68k_fall, m68k_chg;
  logic ack_rise, ack_fall, ack_evt;
  logic done_rise, done_fall, done_evt;
  logic unused_edges;

  pi_edge_sync #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk(PI_CLK), .rst(PI_RST), .d(PI_RD),
    .rise(rd_rise), .fall(rd_fall), .change(rd_chg)
  );

  pi_edge_sync #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk(PI_CLK), .rst(PI_RST), .d(PI_WR),
    .rise(wr_rise), .fall(wr_fall), .change(wr_chg)
  );

  pi_edge_sync #(.STAGES(3)) u_m68k_clk_sync (
    .clk(PI_CLK), .rst(PI_RST), .d(M68K_CLK),
    .rise(m68k_rise), .fall(m68k_fall), .change(m68k_chg)
  );

  pi_edge_sync #(.STAGES(3)) u_ack_sync (
    .clk(PI_CLK), .rst(PI_RST), .d(OP_ACK_TGL),
    .rise(ack_rise), .fall(ack_fall), .change(ack_evt)
  );

  pi_edge_sync #(.STAGES(3)) u_done_sync (
    .clk(PI_CLK), .rst(PI_RST), .d(OP_DONE_TGL),
    .rise(done_rise), .fall(done_fall), .change(done_evt)
  );

  assign unused_edges = ^{rd_fall, rd_chg, wr_fall, wr_chg, m68k_rise, m68k_chg,
                          ack_rise, ack_fall, done_rise, done_fall};

  reg_sel_e sel;
  logic     rd_status;
  logic     a0;
  logic     overrun;

  assign sel       = reg_sel_e'(PI_A);
  assign rd_status = rd_rise && (sel == REG_STATUS);

  // Driven straight from the pins so the Pi sees the bus turn around at once.
  assign PI_D_OE = (sel == REG_STATUS) && PI_RD;

  // Later assignments win: a same-cycle write overrides a handshake clear.
  always_ff @(posedge PI_CLK or posedge PI_RST) begin
    if (PI_RST) begin
      a0                 <= 1'b0;
      overrun            <= 1'b0;
      PI_TXN_IN_PROGRESS <= 1'b0;
      PI_D_OUT           <= '0;
      OP_REQ             <= 1'b0;
      OP_RW              <= 1'b1;
      OP_UDS_N           <= 1'b1;
      OP_LDS_N           <= 1'b1;
      STATUS             <= '0;
    end else begin
      if (ack_evt)  OP_REQ             <= 1'b0;
      if (done_evt) PI_TXN_IN_PROGRESS <= 1'b0;

      if (wr_rise) begin
        unique case (sel)
          REG_ADDR_LO: begin
            a0                 <= PI_D_IN[0];
            PI_TXN_IN_PROGRESS <= 1'b1;
          end
          REG_ADDR_HI: begin
            if (!OP_REQ) begin
              OP_REQ               <= 1'b1;
              OP_RW                <= PI_D_IN[CMD_RW];
              {OP_UDS_N, OP_LDS_N} <= lane_strobes(PI_D_IN[CMD_BYTE], a0);
            end else begin
              overrun <= 1'b1;
            end
          end
          REG_STATUS: STATUS <= PI_D_IN;
          default: ;
        endcase
      end

      if (rd_status) begin
        PI_D_OUT <= status_word(ipl, overrun);
        overrun  <= 1'b0;
      end
    end
  end

  logic [2:0] ipl;
  logic [2:0] ipl_sample;
  logic [2:0] ipl_last;
  logic [2:0] ipl_cnt;
  logic [2:0] ipl_cnt_next;
  logic       ipl_update;
  logic       ipl_pending;

  // A new level must be seen on IPL_FILTER consecutive 68K falling edges.
  always_comb begin
    ipl_sample   = ~M68K_IPL_n;
    ipl_cnt_next = 3'd1;
    if (ipl_sample == ipl_last)
      ipl_cnt_next = (ipl_cnt < FILTER_N) ? ipl_cnt + 3'd1 : ipl_cnt;
    ipl_update = m68k_fall && (ipl_cnt_next >= FILTER_N) && (ipl_sample != ipl);
  end

  always_ff @(posedge PI_CLK or posedge PI_RST) begin
    if (PI_RST) begin
      ipl         <= '0;
      ipl_last    <= '0;
      ipl_cnt     <= '0;
      ipl_pending <= 1'b0;
      PI_IPL_ZERO <= 1'b0;
    end else begin
      if (m68k_fall) begin
        ipl_last <= ipl_sample;
        ipl_cnt  <= ipl_cnt_next;
      end
      if (ipl_update) ipl <= ipl_sample;
      if (rd_status)  ipl_pending <= 1'b0;
      if (ipl_update) ipl_pending <= 1'b1;
      PI_IPL_ZERO <= ipl_pending;
    end
  end

endmodule
